// File: rtl/ram_bit_streamer_pkg.sv
// Shared types and default widths for the RAM bit streamer and its RAM/top-level neighbours.
// No logic here; the FSM encoding and latency-counter width live in one place.
package ram_bit_streamer_pkg;

  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_ADDR_SIZE = 5;
  localparam int MAX_RD_LAT    = 4;
  localparam int LAT_W         = $clog2(MAX_RD_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/ram_bit_shifter.sv
// Parallel-load, MSB-first shift register with bit counter; load takes one edge, msb_o is valid the cycle after.
// Shifts only when shift_i is high, so the caller's handshake stalls it and holds msb_o stable.
module ram_bit_shifter
  import ram_bit_streamer_pkg::*;
#(
  parameter int WIDTH = DEF_RAM_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o,
  output logic             last_bit_o,
  output logic             empty_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (load_i) begin
      sr_d   = data_i;
      cnt_d  = CNT_W'(WIDTH - 1);
      full_d = 1'b1;
    end else if (shift_i && full_q) begin
      sr_d = sr_q << 1;
      // cnt_q counts the index of the bit currently at the MSB
      if (cnt_q == '0) begin
        full_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign msb_o      = sr_q[WIDTH-1];
  assign last_bit_o = full_q && (cnt_q == '0);
  assign empty_o    = ~full_q;

endmodule

// File: rtl/ram_bit_streamer.sv
// Walks a RAM address range and streams each word MSB-first; first bit 2+RD_LAT cycles after start, 1+RD_LAT gap between words.
// bit_valid/bit_out hold steady while bit_ready is low; RAM reads are only issued once the current word is fully drained.
module ram_bit_streamer
  import ram_bit_streamer_pkg::*;
#(
  parameter int RAM_WIDTH = DEF_RAM_WIDTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] start_addr,
  input  logic [ADDR_SIZE:0]   word_count,
  output logic                 mem_rd_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [RAM_WIDTH-1:0] mem_rd_data,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  output logic                 busy,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_SIZE:0]   remain_q, remain_d;
  logic [LAT_W-1:0]     lat_q, lat_d;

  logic sh_load, sh_shift, sh_msb, sh_last, sh_empty;

  ram_bit_shifter #(
    .WIDTH(RAM_WIDTH)
  ) u_shifter (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (sh_load),
    .data_i    (mem_rd_data),
    .shift_i   (sh_shift),
    .msb_o     (sh_msb),
    .last_bit_o(sh_last),
    .empty_o   (sh_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    remain_d   = remain_q;
    lat_d      = lat_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    mem_rd_en  = 1'b0;
    bit_valid  = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = start_addr;
          remain_d = word_count;
          state_d  = (word_count == '0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_rd_en  = 1'b1;
        mem_addr_d = addr_q;
        lat_d      = LAT_W'(RD_LAT);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q == LAT_W'(1)) begin
          sh_load = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_valid = ~sh_empty;
        if (bit_ready && !sh_empty) begin
          sh_shift = 1'b1;
          if (sh_last) begin
            // address wraps naturally at 2**ADDR_SIZE
            addr_d   = addr_q + ADDR_SIZE'(1);
            remain_d = remain_q - (ADDR_SIZE+1)'(1);
            state_d  = (remain_q == (ADDR_SIZE+1)'(1)) ? ST_FINISH : ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      remain_q   <= '0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      remain_q   <= remain_d;
      lat_q      <= lat_d;
    end
  end

  // mem_addr shows the live address only while reading, otherwise the last one issued
  assign mem_addr = (state_q == ST_FETCH) ? addr_q : mem_addr_q;
  assign bit_out  = bit_valid & sh_msb;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_bit_streamer.sv
// Self-checking bench for ram_bit_streamer: table of directed streams, random streams, and reset/detector sequences.
module tb_ram_bit_streamer;
  import ram_bit_streamer_pkg::*;

  localparam int W       = 8;
  localparam int AW      = 5;
  localparam int RD_LAT  = 1;
  localparam int DEPTH   = 1 << AW;
  localparam int P       = W + 1 + RD_LAT;
  localparam int M_ALWAYS = 0;
  localparam int M_RAND   = 1;
  localparam int M_BP     = 2;

  logic          clk = 1'b0;
  logic          rst, start, bit_ready;
  logic [AW-1:0] start_addr;
  logic [AW:0]   word_count;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rd_data;
  logic          bit_out, bit_valid, busy, done;

  always #5 clk = ~clk;

  ram_bit_streamer #(.RAM_WIDTH(W), .ADDR_SIZE(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy), .done(done)
  );

  // RAM with RD_LAT-cycle read pipeline; junk is returned when no read was issued
  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem_rd_en ? ram[mem_addr] : W'($urandom);
  end
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic obs_bits[$];
  int   obs_addrs[$];
  int   done_cnt, done_cyc, hold_err, overlap_err, busy_err, timing_err;

  task automatic run_stream(input int sa, input int cnt, input int mode, input int inj);
    int  hold_left, exp_done;
    logic prev_stall, prev_bit, exp_v, exp_rd, exp_dn, exp_busy;
    obs_bits.delete();
    obs_addrs.delete();
    done_cnt = 0; done_cyc = -1; hold_err = 0; overlap_err = 0; busy_err = 0; timing_err = 0;
    hold_left = 5; prev_stall = 1'b0; prev_bit = 1'b0;
    exp_done = 1 + cnt * P;
    @(posedge clk); #1;
    start_addr = AW'(sa); word_count = (AW+1)'(cnt); start = 1'b1; bit_ready = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      start      = (inj == cyc);
      start_addr = AW'($urandom);
      word_count = (AW+1)'($urandom_range(1, DEPTH));
      case (mode)
        M_RAND:  bit_ready = ($urandom_range(0, 2) != 0);
        M_BP: begin
          if (bit_valid && hold_left > 0) begin
            bit_ready = 1'b0;
            hold_left--;
          end else begin
            bit_ready = 1'b1;
          end
        end
        default: bit_ready = 1'b1;
      endcase
      @(negedge clk);
      if (prev_stall && !(bit_valid && bit_out == prev_bit)) hold_err++;
      if (mem_rd_en && bit_valid) overlap_err++;
      if (mem_rd_en) obs_addrs.push_back(int'(mem_addr));
      if (bit_valid && bit_ready) obs_bits.push_back(bit_out);
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      exp_busy = (done_cyc < 0) || (cyc == done_cyc);
      if (busy !== exp_busy) busy_err++;
      exp_v  = (cyc < exp_done) && (cyc >= 2 + RD_LAT) && (((cyc - 2 - RD_LAT) % P) < W);
      exp_rd = (cyc < exp_done) && (((cyc - 1) % P) == 0);
      exp_dn = (cyc == exp_done);
      if (mode == M_ALWAYS && (bit_valid !== exp_v || mem_rd_en !== exp_rd || done !== exp_dn)) timing_err++;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bit_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag, input int sa, input int cnt, input int mode,
                              input int exp_bits, input int exp_done);
    logic mdl_bits[$];
    int   mdl_addrs[$];
    int   mism;
    for (int w = 0; w < cnt; w++) begin
      int a;
      a = (sa + w) % DEPTH;
      mdl_addrs.push_back(a);
      for (int b = W - 1; b >= 0; b--) mdl_bits.push_back(ram[a][b]);
    end
    check({tag, "_nbits"}, obs_bits.size(), exp_bits);
    mism = 0;
    for (int i = 0; i < obs_bits.size() && i < mdl_bits.size(); i++)
      if (obs_bits[i] !== mdl_bits[i]) mism++;
    check({tag, "_bitdata_mismatches"}, mism, 0);
    check({tag, "_nreads"}, obs_addrs.size(), cnt);
    mism = 0;
    for (int i = 0; i < obs_addrs.size() && i < mdl_addrs.size(); i++)
      if (obs_addrs[i] != mdl_addrs[i]) mism++;
    check({tag, "_addr_mismatches"}, mism, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    if (exp_done >= 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_hold_violations"}, hold_err, 0);
    check({tag, "_rd_during_valid"}, overlap_err, 0);
    check({tag, "_busy_errors"}, busy_err, 0);
    if (mode == M_ALWAYS) check({tag, "_timing_errors"}, timing_err, 0);
  endtask

  typedef struct {
    int sa; int cnt; int mode; int inj;
    int np; int pa0; int pv0; int pa1; int pv1;
    int exp_bits; int exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int flags[$];
    int cnt_bad;
    vecs[0] = '{3,  1,  M_ALWAYS, 0, 1, 3,  'hA5, 0, 0,    8,   11};
    vecs[1] = '{31, 2,  M_ALWAYS, 0, 2, 31, 'h01, 0, 'hFF, 16,  21};
    vecs[2] = '{0,  0,  M_ALWAYS, 0, 0, 0,  0,    0, 0,    0,   1};
    vecs[3] = '{5,  2,  M_ALWAYS, 6, 0, 0,  0,    0, 0,    16,  21};
    vecs[4] = '{0,  1,  M_BP,     0, 1, 0,  'h80, 0, 0,    8,   16};
    vecs[5] = '{10, 32, M_ALWAYS, 0, 0, 0,  0,    0, 0,    256, 321};
    vecs[6] = '{7,  3,  M_RAND,   0, 0, 0,  0,    0, 0,    24,  -1};

    for (int i = 0; i < DEPTH; i++) ram[i] = W'($urandom);
    rst = 1'b1; start = 1'b0; bit_ready = 1'b0; start_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_mem_rd_en", mem_rd_en, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_bit_out", bit_out, 0);
    check("reset_bit_valid", bit_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].np > 0) ram[vecs[v].pa0] = W'(vecs[v].pv0);
      if (vecs[v].np > 1) ram[vecs[v].pa1] = W'(vecs[v].pv1);
      run_stream(vecs[v].sa, vecs[v].cnt, vecs[v].mode, vecs[v].inj);
      check_stream($sformatf("vec%0d", v), vecs[v].sa, vecs[v].cnt, vecs[v].mode,
                   vecs[v].exp_bits, vecs[v].exp_done);
    end

    // random streams against the model
    for (int r = 0; r < 8; r++) begin
      int sa, cnt, mode, inj;
      for (int i = 0; i < DEPTH; i++) ram[i] = W'($urandom);
      sa   = $urandom_range(0, DEPTH - 1);
      cnt  = $urandom_range(0, DEPTH);
      mode = $urandom_range(0, 1);
      inj  = (cnt > 0) ? $urandom_range(1, P) : 0;
      run_stream(sa, cnt, mode, inj);
      check_stream($sformatf("rand%0d", r), sa, cnt, mode, cnt * W, (mode == M_ALWAYS) ? 1 + cnt * P : -1);
    end

    // reset during the second word of a three-word stream
    @(posedge clk); #1;
    start_addr = AW'(4); word_count = (AW+1)'(3); start = 1'b1; bit_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_pre_valid", bit_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    cnt_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy || mem_rd_en || bit_valid) cnt_bad++;
    end
    check("rst_quiet_cycles", cnt_bad, 0);
    run_stream(20, 1, M_ALWAYS, 0);
    check_stream("post_rst", 20, 1, M_ALWAYS, 8, 11);

    // serial 001 detector fed from the transferred bits
    ram[0] = 8'h24;
    ram[1] = 8'h24;
    run_stream(0, 2, M_ALWAYS, 0);
    check_stream("detect", 0, 2, M_ALWAYS, 16, 21);
    for (int i = 2; i < obs_bits.size(); i++)
      if (obs_bits[i-2] == 1'b0 && obs_bits[i-1] == 1'b0 && obs_bits[i] == 1'b1) flags.push_back(i + 1);
    check("detect_nflags", flags.size(), 4);
    if (flags.size() == 4) begin
      check("detect_flag0", flags[0], 3);
      check("detect_flag1", flags[1], 6);
      check("detect_flag2", flags[2], 11);
      check("detect_flag3", flags[3], 14);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
